pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline control unit for the five-stage core. It drives the `stall[5:0]` vector and the `flush` line consumed by every inter-stage register (pc_reg, if_id, id_ex, ex_mem, mem_wb) and supplies the redirect PC on exceptions and `eret`. Stall requests arrive from ID (load-use hazard) and EX (multi-cycle mult/div). Exceptions arrive from MEM. A small FSM suppresses stale stall requests in the cycle after a flush. The block also keeps saturating performance counters and a stall watchdog.

## Interface
- EXC_VECTOR, 32'h0000_0020, handler entry PC for all non-`eret` exceptions.
- MAX_STALL, 1024, number of consecutive stalled cycles that sets `stall_timeout`.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- stallreq_from_id  in  1  ID requests a stall (load-use hazard).
- stallreq_from_ex  in  1  EX requests a stall (multi-cycle op busy).
- excepttype_i  in  32  final exception type from MEM; 0 means no exception.
- cp0_epc_i  in  32  current EPC from CP0; used for `eret`.
- cnt_clr  in  1  clears the counters and the timeout flag.
- stall  out  6  bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb; 1 = Stop.
- flush  out  1  1 = Flush all pipeline registers.
- new_pc  out  32  redirect target; valid only while `flush` = 1.
- stall_cycles  out  32  saturating count of cycles with stall[0] = 1.
- flush_count  out  16  saturating count of flush pulses.
- stall_timeout  out  1  sticky watchdog flag.

## Operation
- FSM states:
  - RUN, the reset state.
  - FLUSHED, a one-cycle shadow that follows a flush.
- In RUN, the first matching rule applies:
  1. `excepttype_i` != 0: flush = 1, stall = 0, next state FLUSHED.
  2. `stallreq_from_ex`: stall = 6'b001111.
  3. `stallreq_from_id`: stall = 6'b000111.
  4. Otherwise: stall = 0, flush = 0.
- `new_pc` decode while flush = 1:
  - `excepttype_i` = 32'h0000_000e (`eret`): `new_pc` = `cp0_epc_i`.
  - Any other nonzero value (1 interrupt, 8 syscall, a invalid, d trap, c overflow): `new_pc` = EXC_VECTOR.
  - While flush = 0, `new_pc` = 0.
- In FLUSHED:
  - stall = 0 and flush = 0, regardless of the request and exception inputs. These inputs originate from squashed instructions.
  - Next state is RUN unconditionally.
- Stall patterns keep the invariant that stall[k] = 1 implies stall[j] = 1 for all j < k. This makes the downstream register insert exactly one bubble at the stall boundary.
- Counters:
  - `stall_cycles` increments when stall[0] = 1 and holds at 32'hFFFF_FFFF.
  - `flush_count` increments on each cycle with flush = 1 and holds at 16'hFFFF.
- Watchdog:
  - Internal run-length counter (11 bits, enough for MAX_STALL) increments each cycle with stall[0] = 1 and resets to 0 when stall[0] = 0.
  - When it reaches MAX_STALL, `stall_timeout` sets and stays set.
  - The run-length counter saturates at MAX_STALL.
- `cnt_clr` zeroes `stall_cycles`, `flush_count`, the run-length counter and `stall_timeout`. If an increment occurs in the same cycle, clear wins.

## Timing
- `stall`, `flush` and `new_pc` are combinational from the inputs and the current state, with zero latency. Pipeline registers sample them at the same edge that the request is raised.
- The FSM, counters and `stall_timeout` are registered. Their visible effect appears one cycle after the triggering condition.
- While `rst` = 1, `stall`, `flush` and `new_pc` are forced to 0 combinationally.
- Reset values: state RUN, `stall_cycles` 0, `flush_count` 0, run-length 0, `stall_timeout` 0.
- Simultaneous events:
  - Exception with any stall request: flush wins and stall = 0.
  - Both stall requests: the EX pattern applies.
  - Back-to-back exceptions: the second is ignored in FLUSHED. It is honoured if it is still present in the following cycle, which starts in RUN.
- Reset mid-stall or mid-flush: the next state is RUN and all counters are 0. No pulse survives.

## Structure
- Constants belong in `define.v`:
  - Stop/NoStop, Flush/NoFlush.
  - Exception codes, including the `eret` code 32'h0000_000e.
  - The stall patterns `STALL_ID` (6'b000111) and `STALL_EX` (6'b001111).
- One sub-module, `ctrl_perf`, holds both saturating counters, the run-length counter and the watchdog. Its inputs are clk, rst, `stall[0]`, `flush` and `cnt_clr`.
- The FSM and the output decode stay in `pipe_ctrl`.

## Test plan
- `stallreq_from_id` = 1 for 3 cycles → `stall` = 6'b000111 on those cycles; `stall_cycles` reads 3 one cycle after the last stall.
- `stallreq_from_ex` and `stallreq_from_id` both held 2 cycles → `stall` = 6'b001111; then release → `stall` = 0.
- `excepttype_i` = 32'h8 with `stallreq_from_ex` = 1 → `flush` = 1, `stall` = 0, `new_pc` = 32'h20. Next cycle, with the inputs still asserted → `flush` = 0, `stall` = 0. Cycle after that → `flush` = 1 again. `flush_count` = 2.
- `excepttype_i` = 32'he, `cp0_epc_i` = 32'hBFC0_0100 → `new_pc` = 32'hBFC0_0100, `flush` = 1 for exactly one cycle.
- MAX_STALL = 4, stall held 4 cycles → `stall_timeout` = 1 and stays 1 after the stall drops. Assert `cnt_clr` during an active stall → all counters and the flag read 0 the next cycle.
- `rst` asserted in the middle of the FLUSHED state → outputs 0 during reset; after release, state is RUN, counters read 0, and a fresh `stallreq_from_id` produces 6'b000111 immediately.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants, FSM state type and redirect helper for the pipeline control unit.
// Stall patterns, flush polarity and exception codes used by pipe_ctrl and its users.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN,
        FLUSHED
    } ctrl_state_e;

    localparam logic STOP     = 1'b1;
    localparam logic NO_STOP  = 1'b0;
    localparam logic FLUSH    = 1'b1;
    localparam logic NO_FLUSH = 1'b0;

    localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
    localparam logic [31:0] EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_INVALID = 32'h0000_000a;
    localparam logic [31:0] EXC_OV      = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

    localparam logic [5:0] STALL_NONE = {6{NO_STOP}};
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;

    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0020;
    localparam int          DEF_MAX_STALL  = 1024;

    // eret returns to EPC; every other exception enters the common handler.
    function automatic logic [31:0] redirect_pc(input logic [31:0] excepttype,
                                                input logic [31:0] epc,
                                                input logic [31:0] vector);
        return (excepttype == EXC_ERET) ? epc : vector;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stall/flush control bundle between the pipeline stages and pipe_ctrl.
// master is the control unit; slave is the pipeline side.
interface pipe_ctrl_if;
    logic        stallreq_from_id;
    logic        stallreq_from_ex;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;

    modport master (
        input  stallreq_from_id,
        input  stallreq_from_ex,
        input  excepttype_i,
        input  cp0_epc_i,
        output stall,
        output flush,
        output new_pc
    );

    modport slave (
        output stallreq_from_id,
        output stallreq_from_ex,
        output excepttype_i,
        output cp0_epc_i,
        input  stall,
        input  flush,
        input  new_pc
    );
endinterface

// File: rtl/pipe_ctrl_perf.sv
// Saturating stall/flush counters plus a stall-run watchdog for pipe_ctrl.
// A clear request overrides any increment in the same cycle.
module pipe_ctrl_perf #(
    parameter int MAX_STALL = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_pc,
    input  logic        flush,
    input  logic        cnt_clr,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count,
    output logic        stall_timeout
);
    localparam int                RUN_W   = $clog2(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);

    logic [31:0]      stall_cycles_reg, stall_cycles_next;
    logic [15:0]      flush_count_reg, flush_count_next;
    logic [RUN_W-1:0] run_len_reg, run_len_next;
    logic             timeout_reg, timeout_next;

    always_comb begin
        stall_cycles_next = stall_cycles_reg;
        flush_count_next  = flush_count_reg;
        run_len_next      = run_len_reg;
        timeout_next      = timeout_reg;
        if (cnt_clr) begin
            stall_cycles_next = '0;
            flush_count_next  = '0;
            run_len_next      = '0;
            timeout_next      = 1'b0;
        end else begin
            if (stall_pc && stall_cycles_reg != '1)
                stall_cycles_next = stall_cycles_reg + 32'd1;
            if (flush && flush_count_reg != '1)
                flush_count_next = flush_count_reg + 16'd1;
            if (!stall_pc)
                run_len_next = '0;
            else if (run_len_reg != RUN_MAX)
                run_len_next = run_len_reg + 1'b1;
            // Flag rises on the edge that closes the MAX_STALL-th stalled cycle.
            timeout_next = timeout_reg | (run_len_next == RUN_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_reg <= '0;
            flush_count_reg  <= '0;
            run_len_reg      <= '0;
            timeout_reg      <= 1'b0;
        end else begin
            stall_cycles_reg <= stall_cycles_next;
            flush_count_reg  <= flush_count_next;
            run_len_reg      <= run_len_next;
            timeout_reg      <= timeout_next;
        end
    end

    assign stall_cycles  = stall_cycles_reg;
    assign flush_count   = flush_count_reg;
    assign stall_timeout = timeout_reg;
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: stall vector, flush and redirect PC for the five-stage core.
// A one-cycle FLUSHED shadow masks requests raised by squashed instructions.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
    parameter int          MAX_STALL  = DEF_MAX_STALL
) (
    input  logic           clk,
    input  logic           rst,
    pipe_ctrl_if.master    bus,
    input  logic           cnt_clr,
    output logic [31:0]    stall_cycles,
    output logic [15:0]    flush_count,
    output logic           stall_timeout
);
    ctrl_state_e state_reg, state_next;

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= RUN;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next  = RUN;
        bus.stall   = STALL_NONE;
        bus.flush   = NO_FLUSH;
        bus.new_pc  = '0;
        if (!rst && state_reg == RUN) begin
            if (bus.excepttype_i != EXC_NONE) begin
                bus.flush  = FLUSH;
                bus.new_pc = redirect_pc(bus.excepttype_i, bus.cp0_epc_i, EXC_VECTOR);
                state_next = FLUSHED;
            end else if (bus.stallreq_from_ex) begin
                bus.stall = STALL_EX;
            end else if (bus.stallreq_from_id) begin
                bus.stall = STALL_ID;
            end
        end
    end

    pipe_ctrl_perf #(
        .MAX_STALL (MAX_STALL)
    ) u_perf (
        .clk           (clk),
        .rst           (rst),
        .stall_pc      (bus.stall[0]),
        .flush         (bus.flush),
        .cnt_clr       (cnt_clr),
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count),
        .stall_timeout (stall_timeout)
    );
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios then random traffic
// compared against a cycle-level behavioural model.
module tb_pipe_ctrl;
    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cnt_clr = 1'b0;
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
    logic        stall_timeout;

    pipe_ctrl_if bus();

    pipe_ctrl #(
        .EXC_VECTOR (32'h0000_0020),
        .MAX_STALL  (MAXS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus.master),
        .cnt_clr       (cnt_clr),
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count),
        .stall_timeout (stall_timeout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state: whether the previous cycle flushed, counters as wide ints.
    bit      m_shadow = 0;
    longint  m_stall_cycles = 0;
    longint  m_flush_count = 0;
    int      m_run = 0;
    bit      m_timeout = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check combinational outputs, clock, update model, check counters.
    task automatic step(input bit r, input bit id, input bit ex, input logic [31:0] exc,
                        input logic [31:0] epc, input bit clr);
        int          stages;
        logic [5:0]  e_stall;
        bit          e_flush;
        logic [31:0] e_pc;
        @(negedge clk);
        rst = r;
        bus.stallreq_from_id = id;
        bus.stallreq_from_ex = ex;
        bus.excepttype_i = exc;
        bus.cp0_epc_i = epc;
        cnt_clr = clr;
        #1;
        stages = 0;
        e_flush = 0;
        e_pc = 0;
        if (!r && !m_shadow) begin
            if (exc != 0) begin
                e_flush = 1;
                e_pc = (exc == 32'he) ? epc : 32'h20;
            end else if (ex) stages = 4;
            else if (id) stages = 3;
        end
        e_stall = 6'((1 << stages) - 1);
        chk("stall", 32'(bus.stall), 32'(e_stall));
        chk("flush", 32'(bus.flush), 32'(e_flush));
        chk("new_pc", bus.new_pc, e_pc);
        $display("cyc rst=%0b id=%0b ex=%0b exc=%h clr=%0b -> stall=%b flush=%0b new_pc=%h",
                 r, id, ex, exc, clr, bus.stall, bus.flush, bus.new_pc);
        @(posedge clk);
        if (r) begin
            m_shadow = 0; m_stall_cycles = 0; m_flush_count = 0; m_run = 0; m_timeout = 0;
        end else begin
            m_shadow = e_flush;
            if (clr) begin
                m_stall_cycles = 0; m_flush_count = 0; m_run = 0; m_timeout = 0;
            end else begin
                if (stages > 0 && m_stall_cycles < 64'hFFFF_FFFF) m_stall_cycles++;
                if (e_flush && m_flush_count < 65535) m_flush_count++;
                m_run = (stages > 0) ? ((m_run < MAXS) ? m_run + 1 : MAXS) : 0;
                if (m_run == MAXS) m_timeout = 1;
            end
        end
        #1;
        chk("stall_cycles", stall_cycles, 32'(m_stall_cycles));
        chk("flush_count", 32'(flush_count), 32'(m_flush_count));
        chk("stall_timeout", 32'(stall_timeout), 32'(m_timeout));
    endtask

    logic [31:0] codes [6] = '{32'h1, 32'h8, 32'ha, 32'hd, 32'hc, 32'he};

    initial begin
        bus.stallreq_from_id = 0;
        bus.stallreq_from_ex = 0;
        bus.excepttype_i = 0;
        bus.cp0_epc_i = 0;

        // Reset state
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 32'h8, 32'h1234, 0);

        // Load-use stall for three cycles
        repeat (3) step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("stall_cycles_after_id3", stall_cycles, 32'd3);

        // Both requests: EX pattern wins, then release
        repeat (2) step(0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Syscall with EX stall: flush, shadow, flush again
        repeat (3) step(0, 0, 1, 32'h8, 0, 0);
        chk("flush_count_after_two", 32'(flush_count), 32'd2);
        step(0, 0, 0, 0, 0, 0);

        // eret redirects to EPC for exactly one cycle
        step(0, 0, 0, 32'he, 32'hBFC0_0100, 0);
        step(0, 0, 0, 0, 32'hBFC0_0100, 0);

        // Watchdog: four stalled cycles set the sticky flag
        repeat (MAXS) step(0, 1, 0, 0, 0, 0);
        chk("timeout_set", 32'(stall_timeout), 32'd1);
        step(0, 0, 0, 0, 0, 0);
        chk("timeout_sticky", 32'(stall_timeout), 32'd1);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 1);
        chk("clr_stall_cycles", stall_cycles, 32'd0);
        chk("clr_timeout", 32'(stall_timeout), 32'd0);
        step(0, 0, 0, 0, 0, 0);

        // Reset during the FLUSHED shadow
        step(0, 0, 0, 32'h1, 0, 0);
        step(1, 1, 0, 32'h1, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bit          r, id, ex, clr;
            logic [31:0] exc;
            r   = ($urandom_range(0, 59) == 0);
            id  = ($urandom_range(0, 9) < 7);
            ex  = ($urandom_range(0, 9) < 3);
            clr = ($urandom_range(0, 39) == 0);
            exc = ($urandom_range(0, 5) == 0) ? codes[$urandom_range(0, 5)] : 32'h0;
            step(r, id, ex, exc, $urandom, clr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
